// File: rtl/d_cache.sv
// ============================================================================
//  Module   : d_cache
//  Purpose  : Direct-mapped, write-back, write-allocate data cache with a
//             combinational hit path and a mem_ready handshake for misses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int c_IW = $clog2(NUM_LINES);
  localparam int c_TW = 28 - c_IW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic              r_valid [NUM_LINES];
  logic              r_dirty [NUM_LINES];
  logic [c_TW-1:0]   r_tag   [NUM_LINES];
  logic [127:0]      r_data  [NUM_LINES];

  logic [1:0]        w_offset;
  logic [c_IW-1:0]   w_index;
  logic [c_TW-1:0]   w_tag;
  logic              w_req;
  logic              w_hit;

  assign w_offset = proc_addr[1:0];
  assign w_index  = proc_addr[c_IW+1:2];
  assign w_tag    = proc_addr[29:c_IW+2];
  assign w_req    = proc_read | proc_write;
  assign w_hit    = w_req && r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign proc_rdata = r_data[w_index][{w_offset, 5'b0} +: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    proc_stall   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = 28'd0;
    mem_wdata    = 128'd0;
    case (r_state)
      IDLE: begin
        proc_stall = w_req && !w_hit;
        if (w_req && !w_hit) begin
          w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {r_tag[w_index], w_index};
        mem_wdata  = r_data[w_index];
        if (mem_ready) begin
          w_next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // A store that misses completes on the IDLE hit cycle after the refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (r_state == ALLOCATE && mem_ready) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
      r_tag[w_index]   <= w_tag;
      r_data[w_index]  <= mem_rdata;
    end else if (r_state == IDLE && w_hit && proc_write) begin
      r_dirty[w_index] <= 1'b1;
      r_data[w_index][{w_offset, 5'b0} +: 32] <= proc_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_d_cache.sv
// ============================================================================
//  Module   : tb_d_cache
//  Purpose  : Randomized self-checking bench for d_cache against a line model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_cache;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  d_cache #(.NUM_LINES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  bit          m_valid [N];
  bit          m_dirty [N];
  bit [24:0]   m_tag   [N];
  bit [127:0]  m_line  [N];
  bit [127:0]  backing [bit [27:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [127:0] blk(input bit [27:0] a);
    if (backing.exists(a)) return backing[a];
    return {32'(a) * 32'h9E3779B1, 32'(a) ^ 32'hC3C30F0F, 32'(a) + 32'h10000000, ~32'(a)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_line[i]  = '0;
    end
  endfunction

  // One CPU request, with the bench acting as the block memory.
  task automatic do_req(input bit rd, input bit wr, input bit [29:0] addr,
                        input bit [31:0] wdata, input int lat_w, input int lat_a);
    int        idx;
    int        off;
    bit [24:0] tg;
    bit        hit;
    bit        need_wb;
    bit [27:0] wb_addr;
    bit [127:0] wb_data;
    bit [31:0] exp_rd;
    int        exp_stall;
    int        stalls;
    int        cnt;
    int        prev;
    int        cur;
    bit        saw_wb;
    bit        saw_al;
    bit        done;
    idx = int'(addr[4:2]);
    off = int'(addr[1:0]);
    tg  = addr[29:5];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    need_wb = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr = {m_tag[idx], 3'(idx)};
    wb_data = m_line[idx];
    exp_stall = hit ? 0 : 1 + (need_wb ? lat_w : 0) + lat_a;
    if (!hit) begin
      if (need_wb) backing[wb_addr] = wb_data;
      m_line[idx]  = blk(addr[29:2]);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (wr) begin
      m_line[idx][off*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
    exp_rd = m_line[idx][off*32 +: 32];

    @(posedge clk);
    #1;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    stalls = 0; cnt = 0; prev = 0; saw_wb = 0; saw_al = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        check("mem_excl", 128'(mem_read & mem_write), 128'd0);
        cur = mem_write ? 1 : (mem_read ? 2 : 0);
        if (cur != prev) cnt = 0;
        cnt++;
        if (cur == 1 && cnt == 1) begin
          saw_wb = 1'b1;
          check("wb_addr", 128'(mem_addr), 128'(wb_addr));
          check("wb_data", mem_wdata, wb_data);
        end
        if (cur == 2 && cnt == 1) begin
          saw_al = 1'b1;
          check("alloc_addr", 128'(mem_addr), 128'(addr[29:2]));
        end
        if (cur == 2) mem_rdata = blk(mem_addr);
        mem_ready = (cur == 1 && cnt >= lat_w) || (cur == 2 && cnt >= lat_a);
        prev = cur;
      end
    end
    mem_ready = 1'b0;
    check("done", 128'(done), 128'd1);
    check("stall_cycles", 128'(stalls), 128'(exp_stall));
    check("wb_seen", 128'(saw_wb), 128'(need_wb));
    check("alloc_seen", 128'(saw_al), 128'(!hit));
    check("idle_mem", {126'd0, mem_read, mem_write}, 128'd0);
    if (rd && !wr) check("rdata", 128'(proc_rdata), 128'(exp_rd));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, 128'(proc_stall), 128'd0);
    check({tag, "_mem_rw"}, {126'd0, mem_read, mem_write}, 128'd0);
    check({tag, "_mem_addr"}, 128'(mem_addr), 128'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 128'd0);
  endtask

  initial begin
    bit [29:0] a;
    int        r;
    model_reset();
    #12;
    check_quiet("rst");
    check("rst_rdata", 128'(proc_rdata), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_quiet("post_rst");

    // Directed sequence
    backing[28'h1] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_req(1, 0, 30'h4, 32'h0, 1, 3);
    do_req(1, 0, 30'h5, 32'h0, 1, 1);
    do_req(1, 0, 30'h6, 32'h0, 1, 1);
    do_req(1, 0, 30'h7, 32'h0, 1, 1);
    do_req(0, 1, 30'h4, 32'hDEADBEEF, 1, 1);
    do_req(1, 0, 30'h4, 32'h0, 1, 1);
    do_req(1, 0, 30'h24, 32'h0, 2, 1);
    do_req(0, 1, 30'h10, 32'h12345678, 1, 2);
    do_req(1, 0, 30'h10, 32'h0, 1, 1);
    do_req(1, 0, 30'h30, 32'h0, 1, 1);
    do_req(1, 1, 30'h31, 32'hCAFEF00D, 1, 1);
    do_req(1, 0, 30'h31, 32'h0, 1, 1);

    // Asynchronous reset while a refill is outstanding
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    @(posedge clk);
    #1;
    proc_read = 1'b1;
    proc_addr = 30'h48;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_read", 128'(mem_read), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_stall_req", 128'(proc_stall), 128'd1);
    proc_read = 1'b0;
    #1;
    check_quiet("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 0, 30'h48, 32'h0, 1, 2);
    do_req(1, 0, 30'h4, 32'h0, 1, 1);

    // Randomized traffic over a small tag space to force evictions
    for (int k = 0; k < 200; k++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 9);
      do_req(r < 5 || r == 9, r >= 5, a, $urandom,
             $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/d_cache.md
# d_cache

Direct-mapped, write-back, write-allocate data cache. It is the responder on the data-memory port of the CPU's memory stage. It accepts word requests (`proc_read`/`proc_write`, 30-bit word address, 32-bit data) and answers hits in the same cycle. On a miss it raises `proc_stall` and runs a write-back and refill sequence against a slow block memory with a `mem_ready` handshake.

## Interface
- `NUM_LINES`, default 8: number of cache lines. Must be a power of two, at least 2. IW = log2(NUM_LINES).
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `proc_read  in  1`: load request.
- `proc_write  in  1`: store request.
- `proc_addr  in  30`: word address.
- `proc_wdata  in  32`: store data. Stored as-is; no byte swapping.
- `proc_rdata  out  32`: load data. Valid when `proc_read && !proc_stall`.
- `proc_stall  out  1`: request not yet serviced; the CPU holds its pipeline.
- `mem_read  out  1`: block refill request.
- `mem_write  out  1`: block write-back request.
- `mem_addr  out  28`: block address, equal to word address [29:2].
- `mem_wdata  out  128`: victim block. Word 0 is in [31:0].
- `mem_rdata  in  128`: refill block, same word order as `mem_wdata`.
- `mem_ready  in  1`: one-cycle pulse; the current memory request is complete.

## Operation
- Address split:
  - offset = `proc_addr[1:0]`
  - index = `proc_addr[IW+1:2]`
  - tag = `proc_addr[29:IW+2]`
- Each line stores: valid, dirty, tag, and 4x32 data words.
- hit = `(proc_read|proc_write) && valid[index] && tag match`.
- If `proc_read` and `proc_write` are both high, the request is treated as a write.
- FSM states:
  - IDLE:
    - Read hit: `proc_rdata` = line word[offset]; `proc_stall` = 0.
    - Write hit: word[offset] <= `proc_wdata` and dirty <= 1 at the edge; `proc_stall` = 0.
    - Miss with a dirty line -> WRITEBACK. Miss with a clean or invalid line -> ALLOCATE. `proc_stall` = 1 in that same cycle.
    - No request: `proc_stall` = 0 and nothing changes.
  - WRITEBACK:
    - `mem_write` = 1, `mem_addr` = {stored tag, index}, `mem_wdata` = line data.
    - On `mem_ready`, go to ALLOCATE.
  - ALLOCATE:
    - `mem_read` = 1, `mem_addr` = `proc_addr[29:2]`.
    - On `mem_ready`, the line takes `mem_rdata`, valid = 1, dirty = 0, tag = request tag; go to IDLE.
  - Back in IDLE, the held request hits. A store then writes its word and sets dirty.
- `proc_stall` = 1 in WRITEBACK and ALLOCATE. In IDLE it equals `request && !hit`.
- `mem_read` and `mem_write` are decoded from state only (Moore outputs) and are never both high.
- When `mem_read` and `mem_write` are both 0, `mem_addr` and `mem_wdata` are 0.
- `proc_rdata` always shows word[offset] of the indexed line. It is only meaningful on a read hit.
- The CPU holds `proc_addr`, `proc_wdata`, `proc_read` and `proc_write` stable while `proc_stall` = 1. Behaviour is undefined otherwise.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All valid, dirty, tag and data bits = 0.
  - `mem_read` = `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `proc_rdata` = 0; `proc_stall` = 0 while no request is present.
- Hit latency is 0 cycles (combinational).
- Clean miss: 1 cycle to enter ALLOCATE, plus memory latency, plus 1 IDLE cycle with the hit. Minimum 3 cycles of which the first 2 are stalled.
- Dirty miss adds the WRITEBACK phase. Minimum 4 cycles, 3 of them stalled.
- `mem_ready` is sampled only in WRITEBACK or ALLOCATE. In IDLE it is ignored.
- `mem_ready` on the same edge the FSM enters a memory state is not possible; the request is visible for at least one full cycle first.
- Reset asserted mid-miss: `mem_read`/`mem_write` drop at once, all lines are invalid, and no partial fill is kept.
- Index wrap: addresses that differ only in tag map to the same line and evict each other.

## Test plan
- Reset, then read addr 0x0000004 with `mem_ready` pulsed 3 cycles after `mem_read` rises, `mem_rdata` = {0x44,0x33,0x22,0x11} -> `proc_stall` high for 4 cycles, `mem_addr` = 0x0000001, then `proc_rdata` = 0x11 with stall low.
- Read 0x0000005, 0x0000006, 0x0000007 back to back after the fill -> 0x22, 0x33, 0x44, each with no stall and no memory activity.
- Write 0xDEADBEEF to 0x0000004 (hit) -> no stall, line dirty. A following read of 0x0000004 returns 0xDEADBEEF.
- Read 0x0000024 (same index, new tag, NUM_LINES = 8) -> `mem_write` first with `mem_addr` = 0x0000001 and `mem_wdata[31:0]` = 0xDEADBEEF; then `mem_read` with `mem_addr` = 0x0000009.
- Write miss to a clean line -> ALLOCATE only, no `mem_write`. After the refill the stored word is updated and the line is dirty.
- Pull `rst_n` low during ALLOCATE -> `mem_read` falls with no clock edge needed. A re-read of the same address misses again.
